input_buffer: RTL and testbench



---
 rtl/global_params_pkg.sv | 14 +
 rtl/input_buffer_mem.sv | 51 +++++
 rtl/input_buffer.sv | 77 +++++++
 tb/tb_input_buffer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/global_params_pkg.sv
// global_params_pkg
// Shared widths and word/address types for the ML datapath blocks.
// DATA_WIDTH and ADDR_WIDTH are the defaults every datapath block starts from.
// data_t is one signed activation word.
// addr_t is one buffer address.
package global_params_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic        [ADDR_WIDTH-1:0] addr_t;

endpackage : global_params_pkg

// File: rtl/input_buffer_mem.sv
// input_buffer_mem
// Register array that holds the input activations. It has one synchronous
// write port, and reset clears every entry. A combinational read tap lets the
// parent register the read result itself.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high clear of all entries
//   wr_en   write strobe; the parent has already range-qualified it
//   wr_addr write address
//   wr_data word to store
//   rd_addr tap address
//   rd_tap  current contents of rd_addr, or 0 when rd_addr >= DEPTH
module input_buffer_mem
  import global_params_pkg::*;
#(
  parameter int DATA_WIDTH = global_params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = global_params_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic        [ADDR_WIDTH-1:0] wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic        [ADDR_WIDTH-1:0] rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_tap
);

  // The zero initialiser makes power-up contents match the post-reset state.
  logic signed [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Guard the index so that a short array, where DEPTH < 2**ADDR_WIDTH,
  // never yields X.
  always_comb begin
    rd_tap = '0;
    if (int'(rd_addr) < DEPTH) begin
      rd_tap = mem[rd_addr];
    end
  end

endmodule : input_buffer_mem

// File: rtl/input_buffer.sv
// input_buffer
// Dual-port scratch buffer of signed input activations. The input loader
// writes it and the compute array reads it. Reads are registered with
// one-cycle latency. When a read and a write hit the same address, the read
// returns the new data (write-first).
// Ports:
//   clk     rising-edge clock for all state
//   rst     synchronous active-high reset; clears memory and rd_data
//   wr_en   write strobe
//   rd_en   read strobe; when low, rd_data holds its value
//   wr_addr write address; writes at or beyond DEPTH are dropped
//   rd_addr read address; reads at or beyond DEPTH return 0
//   wr_data signed word to write
//   rd_data registered signed read result
module input_buffer
  import global_params_pkg::*;
#(
  parameter int DATA_WIDTH = global_params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = global_params_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic        [ADDR_WIDTH-1:0] wr_addr,
  input  logic        [ADDR_WIDTH-1:0] rd_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] rd_data = '0
);

  logic                         wr_in_range;
  logic                         rd_in_range;
  logic                         wr_go;
  logic                         collide;
  logic signed [DATA_WIDTH-1:0] rd_tap;
  logic signed [DATA_WIDTH-1:0] rd_next;

  assign wr_in_range = int'(wr_addr) < DEPTH;
  assign rd_in_range = int'(rd_addr) < DEPTH;
  assign wr_go       = wr_en && wr_in_range;
  // A write to the address being read wins. Because wr_go is range-qualified,
  // an out-of-range read can never take forwarded data.
  assign collide     = wr_go && (wr_addr == rd_addr);

  input_buffer_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_go),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_tap (rd_tap)
  );

  always_comb begin
    rd_next = rd_tap;
    if (!rd_in_range) begin
      rd_next = '0;
    end else if (collide) begin
      rd_next = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule : input_buffer

// File: tb/tb_input_buffer.sv
// tb_input_buffer
// Runs directed and randomized stimulus against input_buffer. The buffer is
// built short (DEPTH=12) so that addresses 12..15 exercise the out-of-range
// rules. Each cycle the driver computes the rd_data expected after that edge
// from a plain array model and queues it. A separate monitor pops the queue
// after every rising edge and compares.
module tb_input_buffer;
  import global_params_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 wr_en = 1'b0;
  logic                 rd_en = 1'b0;
  logic        [AW-1:0] wr_addr = '0;
  logic        [AW-1:0] rd_addr = '0;
  logic signed [DW-1:0] wr_data = '0;
  logic signed [DW-1:0] rd_data;

  data_t model [2**AW];
  data_t last_exp = '0;
  data_t exp_q [$];
  string name_q [$];
  int    vectors = 0;
  int    miscompares = 0;

  input_buffer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the rd_data expected after the edge.
  task automatic applyStimulus(input bit r, input bit we, input bit re,
                               input int wa, input int ra, input int wd,
                               input string nm);
    data_t e;
    @(negedge clk);
    rst     = r;
    wr_en   = we;
    rd_en   = re;
    wr_addr = wa[AW-1:0];
    rd_addr = ra[AW-1:0];
    wr_data = wd[DW-1:0];
    if (r) begin
      e = '0;
      for (int i = 0; i < 2**AW; i++) model[i] = '0;
    end else begin
      if (!re)                   e = last_exp;
      else if (ra >= DEPTH)      e = '0;
      else if (we && wa == ra)   e = wd[DW-1:0];
      else                       e = model[ra];
      if (we && wa < DEPTH) model[wa] = wd[DW-1:0];
    end
    last_exp = e;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input data_t got, input data_t e);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: rd_data=%0d (0x%h) expected %0d (0x%h)",
               nm, got, got, e, e);
    end
  endtask

  // Monitor: samples after each rising edge once the driver has queued work.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        checkOutput(name_q.pop_front(), rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) model[i] = '0;

    // A write that is presented during reset is discarded.
    applyStimulus(1, 1, 0, 2, 0, 9, "reset");
    applyStimulus(0, 0, 1, 0, 2, 0, "read2_after_reset");
    for (int a = 0; a < 2**AW; a++) applyStimulus(0, 0, 1, 0, a, 0, "read_all_zero");

    applyStimulus(0, 1, 0, 0, 0, 5, "write0_hold");
    applyStimulus(0, 0, 1, 0, 0, 0, "read0_is_5");
    applyStimulus(0, 1, 0, 3, 0, -7, "write3_hold");
    applyStimulus(0, 0, 1, 0, 3, 0, "read3_is_fff9");
    applyStimulus(0, 0, 1, 0, 0, 0, "b2b_read0");
    applyStimulus(0, 0, 1, 0, 3, 0, "b2b_read3");
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 3, 3, 8, "hold_while_write");

    applyStimulus(0, 1, 1, 5, 0, 99, "rw_diff_addr");
    applyStimulus(0, 0, 1, 0, 5, 0, "read5_is_99");
    applyStimulus(0, 1, 0, 0, 0, 11, "write0_11");
    applyStimulus(0, 1, 1, 0, 0, 22, "collision_fwd");
    applyStimulus(0, 0, 1, 0, 0, 0, "read0_is_22");

    applyStimulus(0, 1, 0, 13, 0, 1234, "oor_write");
    applyStimulus(0, 0, 1, 0, 13, 0, "oor_read");
    applyStimulus(0, 1, 1, 13, 13, 777, "oor_collision");
    applyStimulus(0, 1, 1, 1, 15, 321, "oor_read15");
    applyStimulus(0, 0, 1, 0, 1, 0, "read1_is_321");

    // Reset in the middle of activity must wipe everything.
    applyStimulus(1, 1, 1, 4, 3, 55, "mid_reset");
    applyStimulus(0, 0, 1, 0, 3, 0, "read3_after_reset");
    applyStimulus(0, 0, 1, 0, 4, 0, "read4_after_reset");

    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH-1),
                    $urandom_range(0, DEPTH-1), int'($urandom), "random");
    end

    // Drain: the monitor consumes the last queued entry after the next edge.
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_input_buffer
